// File: rtl/node_pkg.sv
// node_pkg: shared widths, sample layout, sequencer states and the saturating subtract
package node_pkg;
  localparam int ARG_WIDTH = 8;
  localparam int VAL_WIDTH = 16;
  localparam int NODE_N = 2;
  typedef struct packed {
    logic [VAL_WIDTH-1:0] target;
    logic [NODE_N-1:0][ARG_WIDTH-1:0] argument;
  } sample_t;
  typedef enum logic [2:0] {S_IDLE, S_ARG, S_RES, S_ERR, S_PRP, S_REPORT, S_NEXT, S_DONE} state_t;
  function automatic logic [VAL_WIDTH-1:0] sat16(input logic [VAL_WIDTH-1:0] a, input logic [VAL_WIDTH-1:0] b);
    logic [VAL_WIDTH:0] d;
    d = {a[VAL_WIDTH-1], a} - {b[VAL_WIDTH-1], b};
    return (d[VAL_WIDTH] == d[VAL_WIDTH-1]) ? d[VAL_WIDTH-1:0] : {d[VAL_WIDTH], {(VAL_WIDTH-1){~d[VAL_WIDTH]}}};
  endfunction
endpackage

// File: rtl/node_sequencer_buffer.sv
// sample_buffer: sample register file, one write port and two combinational read ports
module sample_buffer #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          i_clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [W-1:0]  o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_b
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/node_sequencer.sv
// node_sequencer: loads a sample set and replays it through one node for training or validation
module node_sequencer
  import node_pkg::*;
#(
  parameter int N = 2,
  parameter int DEPTH = 4,
  parameter int EPOCHS = 25
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_start,
  input  logic                     i_mode,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_load_valid,
  output logic                     o_load_ready,
  input  logic [N*8+15:0]          i_load_data,
  output logic                     o_train,
  output logic                     o_argument_valid,
  input  logic                     i_argument_ready,
  output logic [N*8-1:0]           o_argument_data,
  input  logic                     i_result_valid,
  output logic                     o_result_ready,
  input  logic [VAL_WIDTH-1:0]     i_result_data,
  output logic                     o_error_valid,
  input  logic                     i_error_ready,
  output logic [VAL_WIDTH-1:0]     o_error_data,
  input  logic                     i_propagate_valid,
  output logic                     o_propagate_ready,
  input  logic [N*16-1:0]          i_propagate_data,
  output logic                     o_report_valid,
  input  logic                     i_report_ready,
  output logic [VAL_WIDTH-1:0]     o_report_data
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(EPOCHS + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int AB = N * ARG_WIDTH;
  localparam int SW = AB + VAL_WIDTH;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_count, w_count_n, r_index, w_index_n;
  logic [EW-1:0] r_epoch, w_epoch_n;
  logic r_mode, w_mode_n, r_load_ready, w_load, w_unused;
  logic [VAL_WIDTH-1:0] r_err, w_err_n;
  logic [SW-1:0] w_rd_a, w_rd_b;
  logic w_busy_n, w_done_n, w_train_n, w_arg_valid_n, w_res_ready_n, w_err_valid_n, w_prp_ready_n, w_rep_valid_n, w_load_ready_n;
  logic [AB-1:0] w_arg_data_n;
  logic [VAL_WIDTH-1:0] w_err_data_n, w_rep_data_n;
  assign o_load_ready = r_load_ready && !i_clear;
  assign w_load = i_load_valid && o_load_ready;
  // propagate payload is intentionally dropped; only its handshake matters
  assign w_unused = ^{i_propagate_data, w_rd_a[AB-1:0], w_rd_b[SW-1 -: VAL_WIDTH]};
  sample_buffer #(.W(SW), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .i_clock  (i_clock),
    .i_we     (w_load),
    .i_waddr  (r_count[AW-1:0]),
    .i_wdata  (i_load_data),
    .i_raddr_a(r_index[AW-1:0]),
    .o_rdata_a(w_rd_a),
    .i_raddr_b(w_index_n[AW-1:0]),
    .o_rdata_b(w_rd_b)
  );
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_index <= '0;
      r_epoch <= '0;
      r_mode <= 1'b0;
      r_err <= '0;
      r_load_ready <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_train <= 1'b0;
      o_argument_valid <= 1'b0;
      o_argument_data <= '0;
      o_result_ready <= 1'b0;
      o_error_valid <= 1'b0;
      o_error_data <= '0;
      o_propagate_ready <= 1'b0;
      o_report_valid <= 1'b0;
      o_report_data <= '0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_index <= w_index_n;
      r_epoch <= w_epoch_n;
      r_mode <= w_mode_n;
      r_err <= w_err_n;
      r_load_ready <= w_load_ready_n;
      o_busy <= w_busy_n;
      o_done <= w_done_n;
      o_train <= w_train_n;
      o_argument_valid <= w_arg_valid_n;
      o_argument_data <= w_arg_data_n;
      o_result_ready <= w_res_ready_n;
      o_error_valid <= w_err_valid_n;
      o_error_data <= w_err_data_n;
      o_propagate_ready <= w_prp_ready_n;
      o_report_valid <= w_rep_valid_n;
      o_report_data <= w_rep_data_n;
    end
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_index_n = r_index;
    w_epoch_n = r_epoch;
    w_mode_n = r_mode;
    w_err_n = r_err;
    case (r_state)
      S_IDLE: begin
        w_count_n = i_clear ? '0 : w_load ? r_count + 1'b1 : r_count;
        if (i_start && !i_clear) begin
          w_state_n = (w_count_n == '0) ? S_DONE : S_ARG;
          w_mode_n = i_mode;
          w_index_n = '0;
          w_epoch_n = '0;
        end
      end
      S_ARG: w_state_n = i_argument_ready ? S_RES : S_ARG;
      S_RES:
        if (i_result_valid) begin
          w_err_n = sat16(w_rd_a[SW-1 -: VAL_WIDTH], i_result_data);
          w_state_n = r_mode ? S_ERR : S_REPORT;
        end
      S_ERR: w_state_n = i_error_ready ? S_PRP : S_ERR;
      S_PRP: w_state_n = i_propagate_valid ? S_NEXT : S_PRP;
      S_REPORT: w_state_n = i_report_ready ? S_NEXT : S_REPORT;
      S_NEXT:
        if (r_index + 1'b1 < r_count) begin
          w_index_n = r_index + 1'b1;
          w_state_n = S_ARG;
        end else begin
          w_index_n = '0;
          w_state_n = (r_mode && r_epoch < EW'(EPOCHS - 1)) ? S_ARG : S_DONE;
          w_epoch_n = (w_state_n == S_ARG) ? r_epoch + 1'b1 : r_epoch;
        end
      default: w_state_n = S_IDLE;
    endcase
  end
  // outputs are decoded from the next state so they land in flops aligned with it
  always_comb begin
    w_busy_n = w_state_n != S_IDLE && w_state_n != S_DONE;
    w_done_n = w_state_n == S_DONE;
    w_train_n = w_busy_n && w_mode_n;
    w_arg_valid_n = w_state_n == S_ARG;
    w_arg_data_n = w_arg_valid_n ? w_rd_b[AB-1:0] : '0;
    w_res_ready_n = w_state_n == S_RES;
    w_err_valid_n = w_state_n == S_ERR;
    w_err_data_n = w_err_valid_n ? w_err_n : '0;
    w_prp_ready_n = w_state_n == S_PRP;
    w_rep_valid_n = w_state_n == S_REPORT;
    w_rep_data_n = w_rep_valid_n ? w_err_n : '0;
    w_load_ready_n = w_state_n == S_IDLE && w_count_n < CW'(DEPTH);
  end
endmodule

// File: tb/tb_node_sequencer.sv
// tb_node_sequencer: directed run sequence against a behavioural node and an error reference model
module tb_node_sequencer;
  import node_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic i_clear = 0, i_start = 0, i_mode = 0, i_load_valid = 0;
  logic [31:0] i_load_data = '0;
  logic i_argument_ready = 0, i_result_valid = 0, i_error_ready = 0, i_propagate_valid = 0, i_report_ready = 0;
  logic [15:0] i_result_data = '0;
  logic [31:0] i_propagate_data = '0;
  logic o_busy, o_done, o_load_ready, o_train, o_argument_valid, o_result_ready, o_error_valid, o_propagate_ready, o_report_valid;
  logic [15:0] o_argument_data, o_error_data, o_report_data;
  logic [57:0] w_outs;
  assign w_outs = {o_busy, o_done, o_load_ready, o_train, o_argument_valid, o_result_ready, o_error_valid,
                   o_propagate_ready, o_report_valid, o_argument_data, o_error_data, o_report_data};

  node_sequencer #(.N(2), .DEPTH(4), .EPOCHS(25)) dut (
    .i_clock(clk), .i_reset(rst), .i_clear(i_clear), .i_start(i_start), .i_mode(i_mode),
    .o_busy(o_busy), .o_done(o_done), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
    .i_load_data(i_load_data), .o_train(o_train), .o_argument_valid(o_argument_valid),
    .i_argument_ready(i_argument_ready), .o_argument_data(o_argument_data),
    .i_result_valid(i_result_valid), .o_result_ready(o_result_ready), .i_result_data(i_result_data),
    .o_error_valid(o_error_valid), .i_error_ready(i_error_ready), .o_error_data(o_error_data),
    .i_propagate_valid(i_propagate_valid), .o_propagate_ready(o_propagate_ready),
    .i_propagate_data(i_propagate_data), .o_report_valid(o_report_valid),
    .i_report_ready(i_report_ready), .o_report_data(o_report_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit bp = 0, exp_mode = 0;
  logic [15:0] arg_q[$], err_q[$], rep_q[$], res_pend[$], m_arg[$], m_tgt[$];
  int prp_pend = 0, n_prp = 0, n_done = 0, n_trainbad = 0, n_unstable = 0;
  int b_arg, b_err, b_rep, b_prp, b_done, b_tb, b_un;
  bit a_hold = 0, e_hold = 0, r_hold = 0;
  logic [15:0] a_last, e_last, r_last;

  // the node under sequencing just echoes the argument vector back as its 16-bit result
  function automatic logic [15:0] ref_err(input logic [15:0] t, input logic [15:0] r);
    int d;
    d = int'($signed(t)) - int'($signed(r));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      res_pend.delete();
      prp_pend = 0;
      a_hold = 0;
      e_hold = 0;
      r_hold = 0;
    end else begin
      if (o_argument_valid && i_argument_ready) begin
        arg_q.push_back(o_argument_data);
        res_pend.push_back(o_argument_data);
      end
      if (i_result_valid && o_result_ready && res_pend.size() > 0) res_pend.pop_front();
      if (o_error_valid && i_error_ready) begin
        err_q.push_back(o_error_data);
        prp_pend++;
      end
      if (i_propagate_valid && o_propagate_ready) begin
        prp_pend--;
        n_prp++;
      end
      if (o_report_valid && i_report_ready) rep_q.push_back(o_report_data);
      if (o_done) n_done++;
      if (o_train !== (o_busy && exp_mode)) n_trainbad++;
      if (a_hold && (!o_argument_valid || o_argument_data !== a_last)) n_unstable++;
      if (e_hold && (!o_error_valid || o_error_data !== e_last)) n_unstable++;
      if (r_hold && (!o_report_valid || o_report_data !== r_last)) n_unstable++;
      a_hold = o_argument_valid && !i_argument_ready;
      e_hold = o_error_valid && !i_error_ready;
      r_hold = o_report_valid && !i_report_ready;
      a_last = o_argument_data;
      e_last = o_error_data;
      r_last = o_report_data;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      i_argument_ready = 0; i_result_valid = 0; i_error_ready = 0; i_propagate_valid = 0; i_report_ready = 0;
    end else begin
      i_argument_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_error_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_report_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_pend.size() > 0) begin
        if (!i_result_valid) i_result_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        i_result_data = res_pend[0];
      end else i_result_valid = 0;
      if (prp_pend > 0) begin
        if (!i_propagate_valid) begin
          i_propagate_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          i_propagate_data = $urandom;
        end
      end else i_propagate_valid = 0;
    end
  end

  task automatic snap();
    b_arg = arg_q.size(); b_err = err_q.size(); b_rep = rep_q.size(); b_prp = n_prp;
    b_done = n_done; b_tb = n_trainbad; b_un = n_unstable;
  endtask

  task automatic load_sample(input logic [15:0] a, input logic [15:0] t);
    sample_t s;
    bit got;
    s.target = t;
    s.argument = a;
    got = 0;
    @(negedge clk);
    i_load_data = s;
    i_load_valid = 1;
    for (int c = 0; c < 50; c++) begin
      if (o_load_ready) begin
        got = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    i_load_valid = 0;
    chk("load_accept", got, 1);
    if (got) begin
      m_arg.push_back(a);
      m_tgt.push_back(t);
    end
  endtask

  task automatic do_run(input bit m, input bit inject);
    bit ok;
    ok = 0;
    snap();
    exp_mode = m;
    @(negedge clk);
    i_mode = m;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    i_mode = ~m;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      i_start = inject && c == 7;
      i_clear = inject && c == 7;
      if (n_done != b_done) begin
        ok = 1;
        break;
      end
    end
    i_start = 0;
    i_clear = 0;
    repeat (3) @(negedge clk);
    chk("run_completes", ok, 1);
    chk("done_once", n_done - b_done, 1);
    chk("train_level", n_trainbad - b_tb, 0);
    chk("valid_stable", n_unstable - b_un, 0);
  endtask

  task automatic check_beats(input bit m, input int epochs);
    int cnt;
    cnt = m_arg.size();
    chk("arg_beats", arg_q.size() - b_arg, epochs * cnt);
    chk("prp_beats", n_prp - b_prp, m ? epochs * cnt : 0);
    chk("err_beats", err_q.size() - b_err, m ? epochs * cnt : 0);
    chk("rep_beats", rep_q.size() - b_rep, m ? 0 : cnt);
    for (int k = 0; k < arg_q.size() - b_arg && k < epochs * cnt; k++)
      chk("arg_data", arg_q[b_arg + k], m_arg[k % cnt]);
    for (int k = 0; k < err_q.size() - b_err && k < epochs * cnt; k++)
      chk("err_data", err_q[b_err + k], ref_err(m_tgt[k % cnt], m_arg[k % cnt]));
    for (int k = 0; k < rep_q.size() - b_rep && k < cnt; k++)
      chk("rep_data", rep_q[b_rep + k], ref_err(m_tgt[k], m_arg[k]));
  endtask

  task automatic empty_start(input string tag);
    snap();
    @(negedge clk);
    i_start = 1;
    i_mode = 1;
    @(posedge clk);
    #1;
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy"}, o_busy, 0);
    @(negedge clk);
    i_start = 0;
    repeat (3) @(negedge clk);
    chk({tag, "_noarg"}, arg_q.size() - b_arg, 0);
    chk({tag, "_once"}, n_done - b_done, 1);
  endtask

  initial begin
    bit seen;
    #2 rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_outs", w_outs, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_load_ready", o_load_ready, 1);
    empty_start("empty_start");
    load_sample(16'h0000, 16'hFF00);
    load_sample(16'h00FF, 16'h007F);
    load_sample(16'hFF00, 16'hFF00);
    load_sample(16'hFFFF, 16'h007F);
    @(negedge clk);
    chk("full_load_ready", o_load_ready, 0);
    do_run(1, 0);
    check_beats(1, 25);
    do_run(0, 0);
    check_beats(0, 1);
    bp = 1;
    do_run(1, 1);
    check_beats(1, 25);
    do_run(0, 0);
    check_beats(0, 1);
    bp = 0;
    @(negedge clk);
    i_clear = 1;
    @(negedge clk);
    i_clear = 0;
    m_arg.delete();
    m_tgt.delete();
    load_sample(16'h1111, 16'h2222);
    @(negedge clk);
    chk("one_load_ready", o_load_ready, 1);
    i_clear = 1;
    i_load_valid = 1;
    #1;
    chk("clear_blocks_load", o_load_ready, 0);
    @(negedge clk);
    i_clear = 0;
    i_load_valid = 0;
    m_arg.delete();
    m_tgt.delete();
    empty_start("after_clear");
    load_sample(16'h8000, 16'h7FFF);
    load_sample(16'h7FFF, 16'h8000);
    load_sample(16'hFFF9, 16'h0000);
    bp = 1;
    do_run(0, 0);
    check_beats(0, 1);
    if (rep_q.size() - b_rep == 3) begin
      chk("sat_pos", rep_q[b_rep], 16'h7FFF);
      chk("sat_neg", rep_q[b_rep + 1], 16'h8000);
      chk("small_err", rep_q[b_rep + 2], 16'h0007);
    end
    bp = 0;
    do_run(1, 0);
    check_beats(1, 25);
    exp_mode = 1;
    @(negedge clk);
    i_mode = 1;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (o_error_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_err", seen, 1);
    rst = 1;
    #1;
    chk("async_reset_outs", w_outs, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    m_arg.delete();
    m_tgt.delete();
    @(negedge clk);
    load_sample(16'h1234, 16'h0100);
    do_run(0, 0);
    check_beats(0, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
